// File: rtl/pool_window_gen.sv
// Streaming 2x2 stride-2 window generator: one buffered row, each block emitted as one registered window.
// Window valid the cycle after its bottom-right pixel; in_ready falls while a window waits on out_ready.
module pool_window_gen #(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data00,
  output logic [DATA_W-1:0] data01,
  output logic [DATA_W-1:0] data10,
  output logic [DATA_W-1:0] data11,
  output logic              out_last
);
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [DATA_W-1:0] hold;
  logic [DATA_W-1:0] linebuf [IMG_W];
  logic              accept;
  logic              col_end;
  logic              row_end;
  logic [CW-1:0]     col_left;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign col_end  = (col == CW'(IMG_W - 1));
  assign row_end  = (row == RW'(IMG_H - 1));
  // Windows only form on odd columns, so the left pixel is col with bit 0 cleared.
  assign col_left = col & ~CW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      col       <= '0;
      row       <= '0;
      hold      <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      data00    <= '0;
      data01    <= '0;
      data10    <= '0;
      data11    <= '0;
    end else begin
      if (out_valid && out_ready)
        out_valid <= 1'b0;
      if (accept) begin
        if (col_end) begin
          col <= '0;
          row <= row_end ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
        if (row[0]) begin
          if (!col[0]) begin
            hold <= in_data;
          end else begin
            data00    <= linebuf[col_left];
            data10    <= linebuf[col];
            data01    <= hold;
            data11    <= in_data;
            out_valid <= 1'b1;
            out_last  <= row_end && col_end;
          end
        end
      end
    end
  end

  // Line buffer is deliberately unreset: each entry is rewritten on the even row before use.
  always_ff @(posedge clk) begin
    if (!rst && accept && !row[0])
      linebuf[col] <= in_data;
  end
endmodule

// File: tb/tb_pool_window_gen.sv
// Directed bench for pool_window_gen: 4x4 scenarios on one instance, a full 28x28 frame on a second.
module tb_pool_window_gen;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, in_valid, in_ready, out_valid, out_ready, out_last;
  logic [7:0] in_data, data00, data01, data10, data11;

  pool_window_gen #(.IMG_W(4), .IMG_H(4), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .data00(data00), .data01(data01),
    .data10(data10), .data11(data11), .out_last(out_last)
  );

  logic       v28, r28, ov28, or28, l28;
  logic [7:0] d28, q00, q01, q10, q11;

  pool_window_gen #(.IMG_W(28), .IMG_H(28), .DATA_W(8)) dut28 (
    .clk(clk), .rst(rst), .in_valid(v28), .in_ready(r28), .in_data(d28),
    .out_valid(ov28), .out_ready(or28), .data00(q00), .data01(q01),
    .data10(q10), .data11(q11), .out_last(l28)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  logic [32:0] win_q[$];
  int          win_cyc[$];
  int          acc_cyc[$];
  logic [32:0] stall_q[$];

  int          n28 = 0;
  int          nl28 = 0;
  logic [32:0] first28, last28;

  always @(posedge clk) cyc <= cyc + 1;

  // Record consumed windows and accepted pixels, stamped with the cycle count.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        win_q.push_back({data00, data01, data10, data11, out_last});
        win_cyc.push_back(cyc);
      end
      if (in_valid && in_ready)
        acc_cyc.push_back(cyc);
      if (ov28 && or28) begin
        if (n28 == 0) first28 = {q00, q01, q10, q11, l28};
        last28 = {q00, q01, q10, q11, l28};
        n28++;
        if (l28) nl28++;
      end
    end
  end

  // Windows of a 4x4 frame whose pixel value is row*4+col: {d00,d01,d10,d11,last}.
  function automatic logic [32:0] exp_win(input int k);
    case (k)
      0:       return {8'd0,  8'd4,  8'd1,  8'd5,  1'b0};
      1:       return {8'd2,  8'd6,  8'd3,  8'd7,  1'b0};
      2:       return {8'd8,  8'd12, 8'd9,  8'd13, 1'b0};
      default: return {8'd10, 8'd14, 8'd11, 8'd15, 1'b1};
    endcase
  endfunction

  // Index of the bottom-right pixel of window k in the 4x4 stream.
  function automatic int br_pix(input int k);
    case (k)
      0:       return 5;
      1:       return 7;
      2:       return 13;
      default: return 15;
    endcase
  endfunction

  function automatic logic [7:0] pix(input int i, input int off2);
    return 8'((i < 16) ? i : i - 16 + off2);
  endfunction

  task automatic clear_logs();
    win_q.delete();
    win_cyc.delete();
    acc_cyc.delete();
    stall_q.delete();
  endtask

  task automatic send(input int n, input int off2, input bit rv, input bit rr, input int stall);
    int idx = 0;
    int guard = 0;
    int left = 0;
    bit armed;
    armed = (stall > 0);
    while (idx < n && guard < 2000) begin
      if (armed && out_valid) begin
        left  = stall;
        armed = 1'b0;
      end
      in_valid  = rv ? ($urandom_range(0, 1) == 1) : 1'b1;
      in_data   = pix(idx, off2);
      out_ready = (left > 0) ? 1'b0 : (rr ? ($urandom_range(0, 1) == 1) : 1'b1);
      @(negedge clk);
      if (left > 0) begin
        stall_q.push_back({in_ready, data00, data01, data10, data11});
        left--;
      end
      if (in_valid && in_ready) idx++;
      @(posedge clk); #1;
      guard++;
    end
    in_valid = 1'b0;
    while (out_valid && guard < 2000) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      guard++;
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_last !== 1'b0) begin n_bad++; $display("FAIL reset_out_last: got %b want 0", out_last); end
    n_cmp++; if ({data00, data01, data10, data11} !== 32'h0) begin n_bad++; $display("FAIL reset_data: got %h want 00000000", {data00, data01, data10, data11}); end
    n_cmp++; if (ov28 !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid_28: got %b want 0", ov28); end
    rst = 1'b0;
    out_ready = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    out_ready = 1'b1;
  endtask

  task automatic test_basic();
    clear_logs();
    send(16, 0, 1'b0, 1'b0, 0);
    n_cmp++; if (win_q.size() != 4) begin n_bad++; $display("FAIL basic_count: got %0d want 4", win_q.size()); end
    for (int k = 0; k < 4 && k < win_q.size(); k++) begin
      n_cmp++; if (win_q[k] !== exp_win(k)) begin n_bad++; $display("FAIL basic_win%0d: got %h want %h", k, win_q[k], exp_win(k)); end
      if (acc_cyc.size() == 16) begin
        n_cmp++; if (win_cyc[k] != acc_cyc[br_pix(k)] + 1) begin n_bad++; $display("FAIL basic_latency%0d: got %0d want %0d", k, win_cyc[k], acc_cyc[br_pix(k)] + 1); end
      end
    end
    n_cmp++; if (acc_cyc.size() != 16 || acc_cyc[15] - acc_cyc[0] != 15) begin n_bad++; $display("FAIL basic_throughput: got %0d accepts want 16 in 16 cycles", acc_cyc.size()); end
  endtask

  task automatic test_backpressure();
    clear_logs();
    send(16, 0, 1'b0, 1'b0, 5);
    n_cmp++; if (stall_q.size() != 5) begin n_bad++; $display("FAIL bp_stall_cycles: got %0d want 5", stall_q.size()); end
    for (int k = 0; k < stall_q.size(); k++) begin
      n_cmp++; if (stall_q[k] !== {1'b0, 8'd0, 8'd4, 8'd1, 8'd5}) begin n_bad++; $display("FAIL bp_hold%0d: got %h want %h", k, stall_q[k], {1'b0, 8'd0, 8'd4, 8'd1, 8'd5}); end
    end
    n_cmp++; if (acc_cyc.size() != 16) begin n_bad++; $display("FAIL bp_accepts: got %0d want 16", acc_cyc.size()); end
    n_cmp++; if (win_q.size() != 4) begin n_bad++; $display("FAIL bp_count: got %0d want 4", win_q.size()); end
    for (int k = 0; k < 4 && k < win_q.size(); k++) begin
      n_cmp++; if (win_q[k] !== exp_win(k)) begin n_bad++; $display("FAIL bp_win%0d: got %h want %h", k, win_q[k], exp_win(k)); end
    end
  endtask

  task automatic test_back_to_back();
    logic [32:0] e;
    clear_logs();
    send(32, 100, 1'b0, 1'b0, 0);
    n_cmp++; if (win_q.size() != 8) begin n_bad++; $display("FAIL b2b_count: got %0d want 8", win_q.size()); end
    for (int k = 0; k < 8 && k < win_q.size(); k++) begin
      e = exp_win(k % 4);
      if (k >= 4) begin
        e[32:25] = e[32:25] + 8'd100;
        e[24:17] = e[24:17] + 8'd100;
        e[16:9]  = e[16:9]  + 8'd100;
        e[8:1]   = e[8:1]   + 8'd100;
      end
      n_cmp++; if (win_q[k] !== e) begin n_bad++; $display("FAIL b2b_win%0d: got %h want %h", k, win_q[k], e); end
    end
    n_cmp++; if (acc_cyc.size() != 32 || acc_cyc[31] - acc_cyc[0] != 31) begin n_bad++; $display("FAIL b2b_no_gap: got %0d accepts want 32 in 32 cycles", acc_cyc.size()); end
  endtask

  task automatic test_random();
    clear_logs();
    send(16, 0, 1'b1, 1'b1, 0);
    n_cmp++; if (win_q.size() != 4) begin n_bad++; $display("FAIL rand_count: got %0d want 4", win_q.size()); end
    for (int k = 0; k < 4 && k < win_q.size(); k++) begin
      n_cmp++; if (win_q[k] !== exp_win(k)) begin n_bad++; $display("FAIL rand_win%0d: got %h want %h", k, win_q[k], exp_win(k)); end
    end
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_data = 8'(i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL mid_pending: got %b want 1", out_valid); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_out_valid: got %b want 0", out_valid); end
    n_cmp++; if ({data00, data01, data10, data11, out_last} !== 33'h0) begin n_bad++; $display("FAIL mid_outputs: got %h want 0", {data00, data01, data10, data11, out_last}); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL mid_in_ready: got %b want 1", in_ready); end
    out_ready = 1'b1;
    clear_logs();
    send(16, 0, 1'b0, 1'b0, 0);
    n_cmp++; if (win_q.size() != 4) begin n_bad++; $display("FAIL mid_count: got %0d want 4", win_q.size()); end
    for (int k = 0; k < 4 && k < win_q.size(); k++) begin
      n_cmp++; if (win_q[k] !== exp_win(k)) begin n_bad++; $display("FAIL mid_win%0d: got %h want %h", k, win_q[k], exp_win(k)); end
    end
  endtask

  task automatic test_full28();
    int i = 0;
    int guard = 0;
    or28 = 1'b1;
    while (i < 784 && guard < 5000) begin
      v28 = 1'b1;
      d28 = 8'(i);
      @(negedge clk);
      if (v28 && r28) i++;
      @(posedge clk); #1;
      guard++;
    end
    v28 = 1'b0;
    while (ov28 && guard < 5000) begin
      @(posedge clk); #1;
      guard++;
    end
    n_cmp++; if (n28 != 196) begin n_bad++; $display("FAIL w28_count: got %0d want 196", n28); end
    n_cmp++; if (first28 !== {8'd0, 8'd28, 8'd1, 8'd29, 1'b0}) begin n_bad++; $display("FAIL w28_first: got %h want %h", first28, {8'd0, 8'd28, 8'd1, 8'd29, 1'b0}); end
    // Rows 26/27, cols 26/27: pixels 754, 782, 755, 783 taken mod 256.
    n_cmp++; if (last28 !== {8'd242, 8'd14, 8'd243, 8'd15, 1'b1}) begin n_bad++; $display("FAIL w28_last: got %h want %h", last28, {8'd242, 8'd14, 8'd243, 8'd15, 1'b1}); end
    n_cmp++; if (nl28 != 1) begin n_bad++; $display("FAIL w28_last_count: got %0d want 1", nl28); end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b1;
    v28       = 1'b0;
    d28       = 8'h00;
    or28      = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_mid_reset();
    test_full28();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
